// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, captures bus words into a small FIFO and hands {pc, inst} to decode.
// Optional same-cycle bypass of an empty queue: define INST_FETCH_QUEUE_BYPASS_EN.
module inst_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        i_clock,
    input  logic        i_reset,
    output logic [31:0] o_inst_addr,
    input  logic [31:0] i_inst,
    input  logic        i_inst_busy,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    input  logic        i_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [31:0]      pc_q, pc_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      mem_pc_q   [DEPTH];
    logic [31:0]      mem_inst_q [DEPTH];

    logic fifo_empty;
    logic push;
    logic pop;
    logic fifo_wr;
    logic fifo_rd;

    assign fifo_empty  = (count_q == '0);
    assign o_inst_addr = pc_q;

    assign pop  = o_valid & i_ready & ~i_redirect;
    assign push = ~i_inst_busy & ~i_redirect & ((count_q != FULL) | pop);

`ifdef INST_FETCH_QUEUE_BYPASS_EN
    logic bypass;

    // Bypass term avoids the pop->push dependency: with an empty queue there is always room.
    assign bypass  = i_reset & fifo_empty & ~i_inst_busy & ~i_redirect;
    assign o_valid = i_reset & (~fifo_empty | bypass);
    assign o_inst  = bypass ? i_inst : mem_inst_q[rptr_q];
    assign o_pc    = bypass ? pc_q   : mem_pc_q[rptr_q];
    assign fifo_wr = push & ~(bypass & pop);
    assign fifo_rd = pop & ~fifo_empty;
`else
    assign o_valid = ~fifo_empty;
    assign o_inst  = mem_inst_q[rptr_q];
    assign o_pc    = mem_pc_q[rptr_q];
    assign fifo_wr = push;
    assign fifo_rd = pop;
`endif

    always_comb begin
        pc_d    = pc_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (i_redirect) begin
            pc_d    = i_redirect_pc & ~32'h3;
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                pc_d = pc_q + 32'd4;
            end
            if (fifo_wr) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (fifo_rd) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            case ({fifo_wr, fifo_rd})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            pc_q    <= RESET_PC;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is cleared on reset so the head reads as zero while the queue has never been written.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc_q[i]   <= '0;
                mem_inst_q[i] <= '0;
            end
        end else if (fifo_wr) begin
            mem_pc_q[wptr_q]   <= pc_q;
            mem_inst_q[wptr_q] <= i_inst;
        end
    end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch stage sitting directly upstream of the instruction memory on the instruction bus. Owns the fetch program counter, drives the bus address, captures the returned instruction word with its PC into a small FIFO, and presents the pair to the decode stage over a valid/ready handshake. Handles pipeline redirects (branch/jump/trap) by flushing queued words and restarting fetch at the new PC.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded at reset; bits [1:0] must be 0.
- DEPTH, 4, FIFO entries; power of two, 2..16.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- o_inst_addr  out  32  instruction bus address (fetch PC).
- i_inst  in  32  instruction bus read data, valid the same cycle as o_inst_addr.
- i_inst_busy  in  1  instruction bus busy; no capture while high.
- i_redirect  in  1  flush and restart fetch.
- i_redirect_pc  in  32  new fetch PC; bits [1:0] ignored (treated as 0).
- o_valid  out  1  head entry valid toward decode.
- o_inst  out  32  head instruction word.
- o_pc  out  32  PC of head instruction.
- i_ready  in  1  decode accepts head this cycle.

## Operation
- State: fetch PC register `pc`, FIFO storage (DEPTH x 64 bits: pc + inst), read/write pointers, occupancy count 0..DEPTH.
- o_inst_addr = pc (registered, no combinational path from inputs).
- pop = o_valid & i_ready & ~i_redirect.
- push = ~i_inst_busy & ~i_redirect & (count < DEPTH | pop); full queue with simultaneous pop accepts the push.
- On push: write {pc, i_inst} at write pointer; pc <= pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
- On pop: advance read pointer. Push and pop together: count unchanged.
- Pointers wrap modulo DEPTH.
- i_redirect (highest priority): count <= 0, pointers <= 0, pc <= {i_redirect_pc[31:2], 2'b00}; no push, no pop that cycle; i_ready ignored.
- i_inst_busy high: pc holds, no push; pop still allowed.
- o_valid = (count != 0), o_inst/o_pc = head entry (see Configuration for empty case).

## Timing
- Reset (i_reset low, async): pc = RESET_PC, count = 0, pointers = 0, storage cleared, o_valid = 0, o_inst = 0, o_pc = 0, o_inst_addr = RESET_PC.
- Reset release mid-stream: all queued words lost; fetch restarts at RESET_PC on first edge after release.
- Fetch-to-output latency: 1 cycle (word captured at edge N, o_valid high after edge N).
- Steady state with i_ready held high and bus never busy: one instruction per cycle, PCs strictly incrementing by 4.
- Redirect at edge N: first word from new PC fetched in cycle after N, o_valid low for at least one cycle after N.
- i_ready low: queue fills to DEPTH then push stalls; pc holds at first unqueued address.
- o_valid/o_inst/o_pc must remain stable while o_valid & ~i_ready, except on redirect.

## Configuration
- INST_FETCH_QUEUE_BYPASS_EN defined: when count == 0 and push occurs, o_valid = 1, o_inst = i_inst, o_pc = pc combinationally in the same cycle; if i_ready is also high the word is consumed without being written (count stays 0). Fetch-to-output latency 0. o_valid forced 0 while i_reset low.
- Not defined: no bypass; outputs driven only from FIFO head; latency 1 cycle as in Timing.

## Test plan
- Reset, RESET_PC=32'h100, i_ready=1, bus never busy, inst = addr ^ 32'hA5A5_A5A5 -> o_pc sequence 100,104,108,... one per cycle; o_inst matches; first o_valid one cycle after reset release (same cycle with bypass).
- i_ready=0 for 10 cycles, DEPTH=4 -> count saturates at 4, o_inst_addr holds at 32'h110, o_pc stays 32'h100; release i_ready -> 100,104,108,10C,110 with no gap.
- Redirect to 32'h2002 while queue holds 3 entries -> o_valid drops next cycle, next o_pc = 32'h2000, no stale entry emitted.
- i_inst_busy high cycles 3..5 -> no capture, pc frozen, resumes without skipping or duplicating addresses.
- pc = 32'hFFFF_FFF8 -> emits FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert i_reset low mid-stream with full queue -> o_valid 0 immediately (async), o_inst_addr = RESET_PC.
